// File: rtl/spi_log_uart_tx.sv
// ============================================================================
//  Module      : spi_log_uart_tx
//  Description : Byte FIFO plus 8N1 UART transmitter for the SPI sniffer log.
//                Counts bytes lost to overflow and, once space frees, inserts
//                a 0xDF marker so the host log shows where the gap is.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_log_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 6
) (
    input  logic               fifo_clk,
    input  logic               reset,
    input  logic [7:0]         data,
    input  logic               data_valid,
    output logic               tx,
    output logic               uart_busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [7:0]         drop_count,
    output logic               overflow
);

    localparam int                 c_DEPTH      = 1 << FIFO_AW;
    localparam int                 c_BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LOAD = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [FIFO_AW:0]   c_LEVEL_FULL = (FIFO_AW + 1)'(c_DEPTH);
    localparam logic [FIFO_AW:0]   c_LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE    = FIFO_AW'(1);
    localparam logic [7:0]         c_GAP_MARKER = 8'hDF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         r_mem [0:c_DEPTH-1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [7:0]         r_drop_count;
    logic               r_drop_pending;

    // Transmitter state
    state_t             r_state;
    logic [7:0]         r_shift;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]         r_bit;
    logic               r_tx;
    logic               r_busy;

    logic               w_full;
    logic               w_empty;
    logic               w_push_data;
    logic               w_push_mark;
    logic               w_push;
    logic               w_drop;
    logic [7:0]         w_push_byte;
    logic [7:0]         w_head;
    logic               w_baud_done;
    logic               w_pop;
    logic               w_fsm_to_idle;
    logic [FIFO_AW:0]   w_level_next;

    // Full is taken from the current level, so a pop while full still refuses
    // a push in that same cycle.
    assign w_full      = (r_level == c_LEVEL_FULL);
    assign w_empty     = (r_level == '0);
    assign w_push_data = data_valid && !w_full && !r_drop_pending;
    assign w_drop      = data_valid && (w_full || r_drop_pending);
    // The marker only goes in on a cycle without a strobe, so it always lands
    // before any byte that arrives after the gap.
    assign w_push_mark = r_drop_pending && !w_full && !data_valid;
    assign w_push      = w_push_data || w_push_mark;
    assign w_push_byte = w_push_mark ? c_GAP_MARKER : data;
    assign w_head      = r_mem[r_rd_ptr];

    assign w_baud_done   = (r_baud == '0);
    assign w_pop         = !w_empty && ((r_state == S_IDLE) ||
                                        ((r_state == S_STOP) && w_baud_done));
    assign w_fsm_to_idle = w_empty && ((r_state == S_IDLE) ||
                                       ((r_state == S_STOP) && w_baud_done));

    // Occupancy after this cycle's push and pop
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_LEVEL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_LEVEL_ONE;
        end
    end

    // FIFO storage write port; contents need no reset
    always_ff @(posedge fifo_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_byte;
        end
    end

    // FIFO pointers, occupancy and overflow accounting
    always_ff @(posedge fifo_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_drop_count   <= '0;
            r_drop_pending <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_level <= w_level_next;
            if (w_drop) begin
                r_drop_pending <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end else if (w_push_mark) begin
                r_drop_pending <= 1'b0;
            end
        end
    end

    // UART framing FSM with registered line and busy outputs
    always_ff @(posedge fifo_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_level_next != '0) || !w_fsm_to_idle;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_baud  <= c_BAUD_LOAD;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_done) begin
                        r_baud  <= c_BAUD_LOAD;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= c_BAUD_LOAD;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        if (!w_empty) begin
                            // Chain straight into the next start bit, no idle gap
                            r_shift <= w_head;
                            r_baud  <= c_BAUD_LOAD;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign uart_busy  = r_busy;
    assign fifo_level = r_level;
    assign drop_count = r_drop_count;
    assign overflow   = (r_drop_count != 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_spi_log_uart_tx.sv
// ============================================================================
//  Module      : tb_spi_log_uart_tx
//  Description : Self-checking bench for spi_log_uart_tx. Stimulus pushes the
//                bytes it expects on the line into a queue; a UART decoder on
//                tx pops and compares each received frame.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_log_uart_tx;

    // Frame (160 cycles) is longer than a 66-strobe burst at one strobe per
    // two cycles, so the transmitter stays inside its first frame while the
    // FIFO fills.
    localparam int CPB   = 16;
    localparam int AW    = 6;
    localparam int FRAME = 10 * CPB;

    logic          fifo_clk = 1'b0;
    logic          reset    = 1'b0;
    logic [7:0]    data     = 8'h00;
    logic          data_valid = 1'b0;
    logic          tx;
    logic          uart_busy;
    logic [AW:0]   fifo_level;
    logic [7:0]    drop_count;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    int unsigned   cyc = 0;
    logic [7:0]    exp_q[$];
    int unsigned   start_q[$];
    int            m_phase = 0;
    logic [7:0]    m_byte = 8'h00;
    bit            m_bad = 1'b0;

    spi_log_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .fifo_clk   (fifo_clk),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .tx         (tx),
        .uart_busy  (uart_busy),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    always #5 fifo_clk = ~fifo_clk;

    always @(posedge fifo_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; one-cycle strobe, returns at the next negedge
    task automatic wr(input logic [7:0] b, input bit kept);
        data       = b;
        data_valid = 1'b1;
        if (kept) exp_q.push_back(b);
        @(negedge fifo_clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge fifo_clk);
            if (!uart_busy && exp_q.size() == 0) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_level_ne(input int v, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge fifo_clk);
            if (int'(fifo_level) != v) return;
        end
        chk("wait_level_timeout", 1, 0);
    endtask

    // UART decoder: samples every negedge, checks every cycle of every bit
    task automatic monitor();
        int p;
        int s;
        int off;
        logic [7:0] e;
        forever begin
            @(negedge fifo_clk);
            if (!reset) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (tx == 1'b0) begin
                    m_phase = 1;
                    m_bad   = 1'b0;
                    start_q.push_back(cyc);
                end
            end else begin
                p   = m_phase;
                s   = p / CPB;
                off = p % CPB;
                if (s == 0) begin
                    if (tx != 1'b0) m_bad = 1'b1;
                end else if (s <= 8) begin
                    if (off == 0) m_byte[s-1] = tx;
                    else if (tx != m_byte[s-1]) m_bad = 1'b1;
                end else begin
                    if (tx != 1'b1) m_bad = 1'b1;
                end
                if (p == FRAME - 1) begin
                    m_phase = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_unexpected: got %02h expected no frame", m_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_bad || m_byte != e) begin
                            errors++;
                            $display("FAIL rx_byte: got %02h (framing_bad=%0d) expected %02h",
                                     m_byte, m_bad, e);
                        end
                    end
                end else begin
                    m_phase = p + 1;
                end
            end
        end
    endtask

    initial begin
        int peak;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge fifo_clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(uart_busy), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_ovf", int'(overflow), 0);
        reset = 1'b1;
        repeat (2) @(negedge fifo_clk);

        // Single byte: level visible after the write edge, start bit one edge later
        wr(8'hA5, 1'b1);
        chk("single_level_after_wr", int'(fifo_level), 1);
        chk("single_tx_still_idle", int'(tx), 1);
        @(negedge fifo_clk);
        chk("single_tx_start", int'(tx), 0);
        chk("single_level_popped", int'(fifo_level), 0);
        chk("single_busy", int'(uart_busy), 1);
        repeat (FRAME - 1) @(negedge fifo_clk);
        chk("single_busy_in_stop", int'(uart_busy), 1);
        chk("single_tx_stop", int'(tx), 1);
        @(negedge fifo_clk);
        chk("single_busy_done", int'(uart_busy), 0);

        // Back-to-back frames
        start_q.delete();
        peak = 0;
        for (int i = 1; i <= 3; i++) begin
            wr(8'(i), 1'b1);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            @(negedge fifo_clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        wait_idle(5 * FRAME);
        chk("b2b_peak_level", peak, 2);
        chk("b2b_level_end", int'(fifo_level), 0);
        chk("b2b_frames", start_q.size(), 3);
        if (start_q.size() == 3) begin
            chk("b2b_gap_1_2", int'(start_q[1] - start_q[0]), FRAME);
            chk("b2b_gap_2_3", int'(start_q[2] - start_q[1]), FRAME);
        end

        // Overflow: 0x00 goes to the shifter, 0x01..0x40 fill the FIFO, 0x41 drops
        for (int k = 0; k < 66; k++) begin
            wr(8'(k), k <= 64);
            @(negedge fifo_clk);
        end
        exp_q.push_back(8'hDF);
        chk("ovf_level_full", int'(fifo_level), 64);
        chk("ovf_drop_count", int'(drop_count), 1);
        chk("ovf_flag", int'(overflow), 1);

        // Space frees while the marker is still pending: strobes keep dropping
        wait_level_ne(64, 2 * FRAME);
        wr(8'hE1, 1'b0);
        wr(8'hE2, 1'b0);
        wr(8'hE3, 1'b0);
        chk("pend_drop_count", int'(drop_count), 4);
        chk("pend_level_no_push", int'(fifo_level), 63);
        @(negedge fifo_clk);
        chk("pend_marker_pushed", int'(fifo_level), 64);
        wait_level_ne(64, 2 * FRAME);
        wr(8'h77, 1'b1);
        wait_idle(80 * FRAME);
        chk("ovf_drain_level", int'(fifo_level), 0);

        // Saturation: 400 strobes back to back, 65 kept, 335 dropped
        for (int k = 0; k < 400; k++) begin
            wr(8'(k), k <= 64);
        end
        exp_q.push_back(8'hDF);
        chk("sat_drop_count", int'(drop_count), 255);
        chk("sat_ovf", int'(overflow), 1);

        // Reset during data bit 3 of a frame
        begin : find_bit3
            for (int i = 0; i < 3 * FRAME; i++) begin
                @(negedge fifo_clk);
                if (m_phase >= 4 * CPB + 2 && m_phase <= 5 * CPB - 2) disable find_bit3;
            end
            chk("bit3_timeout", 1, 0);
        end
        reset = 1'b0;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(uart_busy), 0);
        chk("midrst_level", int'(fifo_level), 0);
        chk("midrst_drop", int'(drop_count), 0);
        chk("midrst_ovf", int'(overflow), 0);
        exp_q.delete();
        repeat (3) @(negedge fifo_clk);
        chk("midrst_tx_held", int'(tx), 1);
        reset = 1'b1;
        repeat (5) @(negedge fifo_clk);
        chk("post_rst_tx_idle", int'(tx), 1);
        wr(8'h3C, 1'b1);
        wait_idle(3 * FRAME);
        chk("post_rst_level", int'(fifo_level), 0);
        chk("post_rst_drop", int'(drop_count), 0);
        repeat (2 * FRAME) @(negedge fifo_clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
